// File: rtl/riscv_mc_ctrl.sv
// Multicycle control FSM for the RV32I core: fetch/decode/execute/memory/write-back sequencing.
// Optional RISCV_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module riscv_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       cmp_true,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       ir_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retired,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
`ifdef RISCV_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    StRst    = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsBranch, ClsLoad, ClsStore, ClsOpImm, ClsOp, ClsIllegal
  } cls_e;

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             mem_wait;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRst;
      cls_q     <= ClsIllegal;
      tmo_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      tmo_q     <= tmo_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    dec_cls = ClsIllegal;
    case (opcode)
      7'b0110111: dec_cls = ClsLui;
      7'b0010111: dec_cls = ClsAuipc;
      7'b1101111: dec_cls = ClsJal;
      7'b1100111: if (funct3 == 3'b000) dec_cls = ClsJalr;
      7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) dec_cls = ClsBranch;
      7'b0000011: if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) dec_cls = ClsLoad;
      7'b0100011: if (funct3 <= 3'b010) dec_cls = ClsStore;
      7'b0010011: dec_cls = ClsOpImm;
      7'b0110011: dec_cls = ClsOp;
      default:    dec_cls = ClsIllegal;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    tmo_d        = tmo_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    mem_wait     = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    ir_we        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    retired      = 1'b0;

    unique case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else begin
          mem_wait = 1'b1;
        end
      end
      StDecode: begin
        cls_d = dec_cls;
        if (dec_cls == ClsIllegal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (cls_q)
          ClsBranch: begin
            pc_we   = 1'b1;
            pc_sel  = cmp_true ? 2'd1 : 2'd0;
            retired = 1'b1;
            state_d = StFetch;
          end
          ClsJal, ClsJalr: begin
            reg_we  = 1'b1;
            wb_sel  = 2'd2;
            pc_we   = 1'b1;
            pc_sel  = (cls_q == ClsJal) ? 2'd1 : 2'd2;
            retired = 1'b1;
            state_d = StFetch;
          end
          ClsLoad, ClsStore: begin
            alu_b_sel = 1'b1;
            state_d   = StMem;
          end
          ClsOp: state_d = StWb;
          ClsOpImm: begin
            alu_b_sel = 1'b1;
            state_d   = StWb;
          end
          ClsLui: begin
            alu_a_sel = 2'd2;
            alu_b_sel = 1'b1;
            state_d   = StWb;
          end
          ClsAuipc: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 1'b1;
            state_d   = StWb;
          end
          default: state_d = StHalt;
        endcase
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == ClsStore);
        if (mem_ready) begin
          if (cls_q == ClsStore) begin
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else begin
          mem_wait = 1'b1;
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        wb_sel  = (cls_q == ClsLoad) ? 2'd1 : 2'd0;
        pc_we   = 1'b1;
        retired = 1'b1;
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase

    if (mem_wait) begin
      if (tmo_q == TmoLast) begin
        bus_err_d = 1'b1;
        state_d   = StHalt;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    if (state_d != state_q) tmo_d = '0;

    // Suppress architectural commits in a cycle that is about to be reset away.
    if (!rst_n) begin
      pc_we   = 1'b0;
      reg_we  = 1'b0;
      ir_we   = 1'b0;
      retired = 1'b0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

`ifdef RISCV_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != StRst && state_q != StHalt) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retired) instret_cnt_q <= instret_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
Multicycle control FSM for the RV32I core. Sequences the shared datapath through fetch, decode, execute, memory and write-back, and issues all datapath enables and muxes. Runs a single-port memory handshake, bounded by a timeout. Classifies opcodes, flags illegal instructions and stops the core on faults. Sits inside riscv beside the PC, IR, register file and ALU.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before a bus error (must be >= 2)
TMO_W, 5, width of the timeout counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, synchronous, active-low
opcode  in  7  IR[6:0], stable from the cycle after ir_we
funct3  in  3  IR[14:12]
cmp_true  in  1  branch comparator result, valid in EXEC
mem_ready  in  1  memory done; read data valid in the same cycle
pc_we  out  1  PC write enable
pc_sel  out  2  0=PC+4, 1=PC+imm (branch/JAL), 2=(rs1+imm)&~1 (JALR)
ir_we  out  1  IR load from memory read data
mem_req  out  1  memory request
mem_we  out  1  store strobe, qualified by mem_req
mem_addr_sel  out  1  0=PC, 1=ALU result register
alu_a_sel  out  2  0=rs1, 1=PC, 2=zero
alu_b_sel  out  1  0=rs2, 1=immediate
reg_we  out  1  register-file write enable
wb_sel  out  2  0=ALU, 1=load data, 2=PC+4
retired  out  1  one-cycle pulse per completed instruction
illegal  out  1  sticky; illegal instruction caused halt
bus_err  out  1  sticky; memory timeout caused halt
state  out  3  debug view of the FSM state

Behaviour:
- Synchronous active-low reset: any edge with rst_n=0 sets state=RST(0), clears the timeout counter, and clears illegal and bus_err.
- All control outputs are combinational from the registered state, latched instruction class and inputs. In RST they are all 0.
- States: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- RST: outputs 0. Moves to FETCH on the first edge with rst_n=1.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - With mem_ready=1: ir_we=1, then DECODE.
  - Timeout counter increments each waiting cycle. If it reaches MEM_TIMEOUT-1 with mem_ready still 0, set bus_err and go to HALT.
  - Counter clears on every state change.
- DECODE (1 cycle): latch the class from opcode and funct3.
  - Legal: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 (funct3=000), BRANCH 1100011 (funct3 not 010/011), LOAD 0000011 (funct3 in 000,001,010,100,101), STORE 0100011 (funct3 <= 010), OP-IMM 0010011, OP 0110011.
  - Anything else: set illegal, go to HALT. Legal: go to EXEC.
- EXEC:
  - BRANCH: alu_a=rs1, alu_b=rs2; pc_we=1; pc_sel=cmp_true?1:0; retired=1; then FETCH.
  - JAL/JALR: reg_we=1, wb_sel=2, pc_we=1, pc_sel=1 (JAL) or 2 (JALR); retired=1; then FETCH.
  - LOAD/STORE: alu_a=rs1, alu_b=imm; then MEM.
  - OP: alu_a=rs1, alu_b=rs2. OP-IMM: alu_a=rs1, alu_b=imm. LUI: alu_a=zero, alu_b=imm. AUIPC: alu_a=PC, alu_b=imm. All four go to WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. Same timeout rule as FETCH.
  - On mem_ready, STORE: pc_we=1, pc_sel=0, retired=1, then FETCH. LOAD: go to WB.
- WB: reg_we=1; wb_sel=1 for LOAD, else 0; pc_we=1, pc_sel=0; retired=1; then FETCH.
- HALT: all enables 0. Stays until reset; illegal and bus_err hold.
- mem_ready is ignored while mem_req=0.
- Latency with zero-wait memory, counted from FETCH entry: branch/jump 3, ALU/LUI/AUIPC 4, store 4, load 5 cycles. Each memory wait cycle adds 1.
- Reset mid-transaction: mem_req drops the cycle after the reset edge. No pc_we, reg_we or retired pulse occurs.

Optional Feature:
RISCV_PERF_CNT_EN:
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle the state is not RST and not HALT.
  - instret_cnt increments on retired.
  - Both wrap modulo 2^32.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
1. Reset held 3 cycles, then released; instruction ADD (0110011), mem_ready tied 1 -> RST→FETCH→DECODE→EXEC→WB; in WB reg_we=1, wb_sel=0, retired=1; the next FETCH begins 4 cycles after the first.
2. LW (0000011, funct3=010), mem_ready delayed 2 cycles in MEM -> MEM held 3 cycles with mem_req=1, mem_addr_sel=1; then WB with wb_sel=1; 7 cycles total.
3. BEQ: once with cmp_true=1, once with cmp_true=0 -> EXEC pc_we=1 with pc_sel=1, then pc_sel=0; reg_we stays 0; retired=1.
4. Opcode 1111111, and separately LOAD with funct3=111 -> illegal=1, state=HALT; no reg_we/pc_we after DECODE; remains halted until rst_n=0.
5. mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> bus_err=1 and HALT after 16 cycles in FETCH; a pulse on mem_ready at cycle 15 instead completes the fetch normally.
6. With RISCV_PERF_CNT_EN: run 10 ADDs with zero-wait memory -> instret_cnt=10, cycle_cnt=40 at the 10th retire edge; rst_n low mid-EXEC clears both counters and mem_req.
